frequency_window_counter: RTL and testbench

- Downstream consumer of the start/stop strobes produced by frequency_analyzer_synch.
- Measures an input signal over each strobe-bounded window:
  - rising-edge count
  - high-time cycles
  - window length in cycles
- Presents the registered results with a one-cycle valid pulse to the frequency/duty computation logic.
- One instance per analyzer channel (channel 0 and channel 1).

---
 rtl/frequency_window_counter.sv | 156 +++++++++++++++
 tb/tb_frequency_window_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_window_counter.sv
// frequency_window_counter
// Measures an asynchronous input over each window bounded by the analyzer's
// start/stop strobes: rising edges, high-time cycles and window length.
// Results are registered and announced with a one-cycle result_valid pulse.
// One instance serves one analyzer channel.

module frequency_window_counter #(
  parameter int unsigned COUNTER_WIDTH = 32,
  // Synchronizer depth on signal_in; must be at least 2.
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     signal_in,
  input  logic                     start_analyzer,
  input  logic                     stop_analyzer,
  output logic [COUNTER_WIDTH-1:0] edge_count,
  output logic [COUNTER_WIDTH-1:0] high_cycles,
  output logic [COUNTER_WIDTH-1:0] window_cycles,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     overflow
);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
    input logic [COUNTER_WIDTH-1:0] cnt,
    input logic                     inc
  );
    if (inc && (cnt != CNT_MAX)) return cnt + CNT_ONE;
    return cnt;
  endfunction

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     s_sync;
  logic                     s_prev;
  logic                     rise;

  logic [COUNTER_WIDTH-1:0] win_cnt;
  logic [COUNTER_WIDTH-1:0] hi_cnt;
  logic [COUNTER_WIDTH-1:0] edge_cnt;
  logic                     ovf;

  logic [COUNTER_WIDTH-1:0] win_nx;
  logic [COUNTER_WIDTH-1:0] hi_nx;
  logic [COUNTER_WIDTH-1:0] edge_nx;
  logic                     ovf_nx;

  // Synchronizer chain plus edge register; runs every cycle regardless of state.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the shift relies on it).
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      s_prev <= s_sync;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;

  // Values the counters take if the current cycle is counted. The stop cycle
  // belongs to the window, so these are also what gets published on stop.
  assign win_nx  = sat_inc(win_cnt, 1'b1);
  assign hi_nx   = sat_inc(hi_cnt, s_sync);
  assign edge_nx = sat_inc(edge_cnt, rise);
  assign ovf_nx  = ovf
                 | (win_nx  == CNT_MAX)
                 | (hi_nx   == CNT_MAX)
                 | (edge_nx == CNT_MAX);

  // Window control FSM, counters and registered result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      win_cnt       <= '0;
      hi_cnt        <= '0;
      edge_cnt      <= '0;
      ovf           <= 1'b0;
      edge_count    <= '0;
      high_cycles   <= '0;
      window_cycles <= '0;
      overflow      <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          // Stop is meaningless without an open window; start wins over it.
          if (enable && start_analyzer) begin
            state    <= COUNTING;
            busy     <= 1'b1;
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end

        COUNTING: begin
          if (!enable) begin
            // Abort: drop the window silently, previous results stay visible.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (stop_analyzer) begin
              edge_count    <= edge_nx;
              high_cycles   <= hi_nx;
              window_cycles <= win_nx;
              overflow      <= ovf_nx;
              result_valid  <= 1'b1;
            end

            if (start_analyzer) begin
              // Restart (alone) or back-to-back reopen (with stop): the strobe
              // cycle itself is not part of the new window.
              win_cnt  <= '0;
              hi_cnt   <= '0;
              edge_cnt <= '0;
              ovf      <= 1'b0;
            end else if (stop_analyzer) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              win_cnt  <= win_nx;
              hi_cnt   <= hi_nx;
              edge_cnt <= edge_nx;
              ovf      <= ovf_nx;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_window_counter.sv
// Directed testbench for frequency_window_counter: a 32-bit instance covers
// measurement, back-to-back windows, restart, abort and reset; an 8-bit
// instance covers counter saturation.

module tb_frequency_window_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        signal_in;
  logic        start_analyzer;
  logic        stop_analyzer;
  logic [31:0] edge_count;
  logic [31:0] high_cycles;
  logic [31:0] window_cycles;
  logic        result_valid;
  logic        busy;
  logic        overflow;

  logic        sig8;
  logic        start8;
  logic        stop8;
  logic [7:0]  edge_count8;
  logic [7:0]  high_cycles8;
  logic [7:0]  window_cycles8;
  logic        result_valid8;
  logic        busy8;
  logic        overflow8;

  int errors = 0;
  int checks = 0;
  int sq_cnt = 0;
  int rv_seen;
  logic busy_drop;

  frequency_window_counter #(.COUNTER_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .signal_in      (signal_in),
    .start_analyzer (start_analyzer),
    .stop_analyzer  (stop_analyzer),
    .edge_count     (edge_count),
    .high_cycles    (high_cycles),
    .window_cycles  (window_cycles),
    .result_valid   (result_valid),
    .busy           (busy),
    .overflow       (overflow)
  );

  frequency_window_counter #(.COUNTER_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .signal_in      (sig8),
    .start_analyzer (start8),
    .stop_analyzer  (stop8),
    .edge_count     (edge_count8),
    .high_cycles    (high_cycles8),
    .window_cycles  (window_cycles8),
    .result_valid   (result_valid8),
    .busy           (busy8),
    .overflow       (overflow8)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // One clock: sample just after the edge, then advance the square wave
  // (period 20, 50% duty) for the next cycle.
  task automatic tick();
    @(posedge clock);
    #1;
    if (result_valid) rv_seen++;
    if (!busy) busy_drop = 1'b1;
    sq_cnt++;
    signal_in = ((sq_cnt % 20) < 10);
  endtask

  task automatic strobe(input logic st, input logic sp);
    start_analyzer = st;
    stop_analyzer  = sp;
    tick();
    start_analyzer = 1'b0;
    stop_analyzer  = 1'b0;
  endtask

  task automatic strobe8(input logic st, input logic sp);
    start8 = st;
    stop8  = sp;
    tick();
    start8 = 1'b0;
    stop8  = 1'b0;
  endtask

  initial begin
    // NOTE: inputs are driven with blocking assignments just after the clock
    // edge, so the DUT always samples settled values on the next edge.
    reset          = 1'b1;
    enable         = 1'b1;
    signal_in      = 1'b1;
    start_analyzer = 1'b0;
    stop_analyzer  = 1'b0;
    sig8           = 1'b1;
    start8         = 1'b0;
    stop8          = 1'b0;
    rv_seen        = 0;
    busy_drop      = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_window", window_cycles, 0);
    check("rst_high", high_cycles, 0);
    check("rst_edge", edge_count, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 1. Basic measurement: 1000-cycle window of the square wave.
    repeat (98) tick();
    strobe(1'b1, 1'b0);
    check("t1_busy_open", busy, 1);
    busy_drop = 1'b0;
    rv_seen   = 0;
    repeat (999) tick();
    check("t1_busy_held", busy_drop, 0);
    check("t1_no_early_valid", rv_seen, 0);
    strobe(1'b0, 1'b1);
    check("t1_valid", result_valid, 1);
    check("t1_window", window_cycles, 1000);
    check("t1_high", high_cycles, 500);
    check("t1_edge", edge_count, 50);
    check("t1_ovf", overflow, 0);
    check("t1_busy_closed", busy, 0);
    tick();
    check("t1_valid_pulse", result_valid, 0);
    check("t1_hold", window_cycles, 1000);

    // 2. Saturation on the 8-bit instance, input held high.
    strobe8(1'b1, 1'b0);
    repeat (299) tick();
    strobe8(1'b0, 1'b1);
    check("t2_valid", result_valid8, 1);
    check("t2_window", window_cycles8, 255);
    check("t2_high", high_cycles8, 255);
    check("t2_edge", edge_count8, 0);
    check("t2_ovf", overflow8, 1);
    // Overflow flag must clear when the next window opens.
    strobe8(1'b1, 1'b0);
    repeat (9) tick();
    strobe8(1'b0, 1'b1);
    check("t2_small_window", window_cycles8, 10);
    check("t2_small_high", high_cycles8, 10);
    check("t2_small_ovf", overflow8, 0);

    // 3. Back-to-back windows of 500 cycles.
    rv_seen = 0;
    strobe(1'b1, 1'b0);
    busy_drop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (499) tick();
      strobe(1'b1, 1'b1);
      check("t3_valid", result_valid, 1);
      check("t3_window", window_cycles, 500);
      check("t3_high", high_cycles, 250);
      check("t3_edge", edge_count, 25);
    end
    check("t3_busy_never_drops", busy_drop, 0);
    repeat (499) tick();
    strobe(1'b0, 1'b1);
    check("t3_last_window", window_cycles, 500);
    check("t3_valid_count", rv_seen, 4);

    // 4. Abort by dropping enable 200 cycles into a window.
    tick();
    rv_seen = 0;
    strobe(1'b1, 1'b0);
    repeat (199) tick();
    enable = 1'b0;
    tick();
    check("t4_busy", busy, 0);
    check("t4_no_valid", rv_seen, 0);
    check("t4_keep_window", window_cycles, 500);
    check("t4_keep_high", high_cycles, 250);
    check("t4_keep_edge", edge_count, 25);
    enable = 1'b1;
    tick();
    strobe(1'b1, 1'b0);
    repeat (39) tick();
    strobe(1'b0, 1'b1);
    check("t4_after_valid", result_valid, 1);
    check("t4_after_window", window_cycles, 40);
    check("t4_after_high", high_cycles, 20);
    check("t4_after_edge", edge_count, 2);

    // 5. Reset in the middle of a window.
    strobe(1'b1, 1'b0);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_window", window_cycles, 0);
    check("t5_high", high_cycles, 0);
    check("t5_edge", edge_count, 0);
    check("t5_busy", busy, 0);
    check("t5_valid", result_valid, 0);
    rv_seen = 0;
    strobe(1'b0, 1'b1);
    tick();
    check("t5_stop_ignored", rv_seen, 0);
    // Start with enable low is ignored in IDLE.
    enable = 1'b0;
    strobe(1'b1, 1'b0);
    check("t5_start_disabled", busy, 0);
    enable = 1'b1;
    tick();

    // 6. Start while counting restarts the window; start wins over stop in IDLE.
    strobe(1'b1, 1'b1);
    check("t6_start_wins_busy", busy, 1);
    check("t6_start_wins_valid", result_valid, 0);
    rv_seen = 0;
    repeat (299) tick();
    strobe(1'b1, 1'b0);
    check("t6_restart_busy", busy, 1);
    check("t6_restart_no_valid", result_valid, 0);
    repeat (499) tick();
    strobe(1'b0, 1'b1);
    check("t6_valid", result_valid, 1);
    check("t6_window", window_cycles, 500);
    check("t6_high", high_cycles, 250);
    check("t6_single_valid", rv_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
